// File: rtl/mem_requester.sv
// mem_requester: load/store initiator for one port of the shared memory.
// Optional write acks via MEM_REQ_WRITE_ACK_EN; in-order response FIFO.
//
// Ports:
//   i_clk, i_rst (sync, active-high)
//   i_req_valid/o_req_ready, i_req_write, i_req_addr, i_req_data
//   o_rsp_valid/i_rsp_ready, o_rsp_data, o_rsp_write
//   o_mem_op (0 NONE, 1 READ, 2 WRITE), o_mem_addr, o_mem_data
//   i_mem_data (registered read data from the memory)
module mem_requester #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 64,
  parameter int RSP_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_data,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_rsp_write,
  output logic [1:0]        o_mem_op,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data,
  input  logic [DATA_W-1:0] i_mem_data
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int SUM_W = CNT_W + 2;

  localparam logic [1:0] OP_NONE  = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(RSP_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RSP_DEPTH);
  localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(RSP_DEPTH - 1);

  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              due1_q, due1_d;
  logic              due2_q;

  logic [DATA_W-1:0] fifo_q [RSP_DEPTH];
  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              accept;
  logic              due_new;
  logic              push, pop;
  logic [DATA_W-1:0] push_data;
  logic [SUM_W-1:0]  need;

  // Credit covers every response that may still land in the FIFO;
  // registered state only, so a same-cycle pop is not credited.
  assign need = SUM_W'(cnt_q) + SUM_W'(due1_q)
              + SUM_W'(due2_q) + SUM_W'(1);

  assign o_req_ready = !i_rst && (need <= DEPTH_S);
  assign accept      = i_req_valid && o_req_ready;

  assign o_mem_op   = op_q;
  assign o_mem_addr = addr_q;
  assign o_mem_data = data_q;

  assign o_rsp_valid = (cnt_q != '0);
  assign o_rsp_data  = o_rsp_valid ? fifo_q[rptr_q] : '0;

  assign push = due2_q;
  assign pop  = o_rsp_valid && i_rsp_ready;

`ifdef MEM_REQ_WRITE_ACK_EN
  logic wr1_q, wr2_q;
  logic fifo_wr_q [RSP_DEPTH];

  assign due_new     = 1'b1;
  assign push_data   = wr2_q ? '0 : i_mem_data;
  assign o_rsp_write = o_rsp_valid && fifo_wr_q[rptr_q];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr1_q <= 1'b0;
      wr2_q <= 1'b0;
    end else begin
      wr1_q <= accept && i_req_write;
      wr2_q <= wr1_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && push) begin
      fifo_wr_q[wptr_q] <= wr2_q;
    end
  end
`else
  assign due_new     = !i_req_write;
  assign push_data   = i_mem_data;
  assign o_rsp_write = 1'b0;
`endif

  always_comb begin
    op_d   = OP_NONE;
    addr_d = '0;
    data_d = '0;
    due1_d = 1'b0;
    if (accept) begin
      op_d   = i_req_write ? OP_WRITE : OP_READ;
      addr_d = i_req_addr;
      data_d = i_req_data;
      due1_d = due_new;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      op_q   <= OP_NONE;
      addr_q <= '0;
      data_q <= '0;
      due1_q <= 1'b0;
      due2_q <= 1'b0;
    end else begin
      op_q   <= op_d;
      addr_q <= addr_d;
      data_q <= data_d;
      due1_q <= due1_d;
      due2_q <= due1_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wptr_q] <= push_data;
        wptr_q <= (wptr_q == LAST_P) ? '0 : wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= (rptr_q == LAST_P) ? '0 : rptr_q + 1'b1;
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (pop && !push) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge i_clk) begin
    if (!i_rst && push && !pop && cnt_q == DEPTH_C) begin
      $error("mem_requester: response push while FIFO full");
    end
  end
`endif

endmodule

// File: tb/tb_mem_requester.sv
// Directed bench for mem_requester with a one-port memory model.
// Covers reset, RAW, streaming, backpressure, mid-flight reset, acks.
module tb_mem_requester;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [12:0] req_addr;
  logic [63:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_write;
  logic [1:0]  mem_op;
  logic [12:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = '0;

  logic [63:0] mem [8192];

  int n_cmp = 0;
  int n_bad = 0;
  int nxt;
  int got;

  always #5 clk = ~clk;

  mem_requester #(
    .ADDR_W(13), .DATA_W(64), .RSP_DEPTH(4)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_req_valid(req_valid),
    .o_req_ready(req_ready),
    .i_req_write(req_write),
    .i_req_addr(req_addr),
    .i_req_data(req_data),
    .o_rsp_valid(rsp_valid),
    .i_rsp_ready(rsp_ready),
    .o_rsp_data(rsp_data),
    .o_rsp_write(rsp_write),
    .o_mem_op(mem_op),
    .o_mem_addr(mem_addr),
    .o_mem_data(mem_wdata),
    .i_mem_data(mem_rdata)
  );

  always @(posedge clk) begin
    if (rst) begin
      mem_rdata <= '0;
    end else begin
      mem_rdata <= (mem_op == 2'd1) ? mem[mem_addr] : '0;
      if (mem_op == 2'd2) mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w,
                       input int a, input logic [63:0] d);
    req_valid = v;
    req_write = w;
    req_addr  = 13'(a);
    req_data  = d;
  endtask

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b0;
    drive(1'b0, 1'b0, 0, 64'd0);

    // reset held for two edges
    @(negedge clk);
    @(negedge clk);
    chk("rst_op", 64'(mem_op), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wdata", mem_wdata, 64'd0);
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_data", rsp_data, 64'd0);
    chk("rst_write", 64'(rsp_write), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("rel_ready", 64'(req_ready), 64'd1);

`ifdef MEM_REQ_WRITE_ACK_EN
    // write ack interleaved with read response
    rsp_ready = 1'b1;
    drive(1'b1, 1'b1, 3, 64'h55);
    @(negedge clk);
    chk("ack_ready", 64'(req_ready), 64'd1);
    drive(1'b1, 1'b0, 3, 64'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 0, 64'd0);
    @(negedge clk);
    chk("ack_v0", 64'(rsp_valid), 64'd1);
    chk("ack_w0", 64'(rsp_write), 64'd1);
    chk("ack_d0", rsp_data, 64'd0);
    @(negedge clk);
    chk("ack_v1", 64'(rsp_valid), 64'd1);
    chk("ack_w1", 64'(rsp_write), 64'd0);
    chk("ack_d1", rsp_data, 64'h55);
    @(negedge clk);
    chk("ack_end", 64'(rsp_valid), 64'd0);
    rsp_ready = 1'b0;
`else
    // write then read same address, writes give no response
    drive(1'b1, 1'b1, 16, 64'h1234);
    @(negedge clk);
    chk("raw_op_w", 64'(mem_op), 64'd2);
    chk("raw_addr", 64'(mem_addr), 64'h10);
    chk("raw_wdata", mem_wdata, 64'h1234);
    chk("raw_ready", 64'(req_ready), 64'd1);
    drive(1'b1, 1'b0, 16, 64'd0);
    @(negedge clk);
    chk("raw_op_r", 64'(mem_op), 64'd1);
    drive(1'b0, 1'b0, 0, 64'd0);
    @(negedge clk);
    chk("raw_early", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    chk("raw_valid", 64'(rsp_valid), 64'd1);
    chk("raw_data", rsp_data, 64'h1234);
    chk("raw_write", 64'(rsp_write), 64'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("raw_single", 64'(rsp_valid), 64'd0);
    rsp_ready = 1'b0;
`endif

    // preload mem[k] = k + 100 through the DUT
    rsp_ready = 1'b1;
    nxt = 0;
    for (int c = 0; c < 40 && nxt < 8; c++) begin
      if (req_ready) begin
        drive(1'b1, 1'b1, nxt, 64'(nxt + 100));
        nxt++;
      end else begin
        drive(1'b0, 1'b0, 0, 64'd0);
      end
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 0, 64'd0);
    chk("pre_count", 64'(nxt), 64'd8);
    repeat (4) @(negedge clk);
    chk("pre_idle", 64'(rsp_valid), 64'd0);

    // streaming: one read per cycle, one response per cycle
    for (int i = 0; i < 11; i++) begin
      if (i < 8) begin
        chk("st_ready", 64'(req_ready), 64'd1);
        drive(1'b1, 1'b0, i, 64'd0);
      end else begin
        drive(1'b0, 1'b0, 0, 64'd0);
      end
      if (i >= 3) begin
        chk("st_valid", 64'(rsp_valid), 64'd1);
        chk("st_data", rsp_data, 64'(i - 3 + 100));
      end
      @(negedge clk);
    end
    chk("st_end", 64'(rsp_valid), 64'd0);

    // backpressure: four credits then stall
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_ready", 64'(req_ready), 64'd1);
      drive(1'b1, 1'b0, i, 64'd0);
      @(negedge clk);
    end
    chk("bp_stall", 64'(req_ready), 64'd0);
    drive(1'b0, 1'b0, 0, 64'd0);
    @(negedge clk);
    @(negedge clk);
    chk("bp_head_v", 64'(rsp_valid), 64'd1);
    chk("bp_head_d", rsp_data, 64'd100);
    chk("bp_full", 64'(req_ready), 64'd0);
    rsp_ready = 1'b1;
    nxt = 4;
    got = 0;
    for (int c = 0; c < 30 && got < 6; c++) begin
      if (rsp_valid) begin
        chk("bp_data", rsp_data, 64'(got + 100));
        got++;
      end
      if (req_ready && nxt < 6) begin
        drive(1'b1, 1'b0, nxt, 64'd0);
        nxt++;
      end else begin
        drive(1'b0, 1'b0, 0, 64'd0);
      end
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 0, 64'd0);
    chk("bp_got", 64'(got), 64'd6);
    chk("bp_drain", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    chk("bp_nodup", 64'(rsp_valid), 64'd0);

    // reset while two reads are in flight
    chk("mr_ready", 64'(req_ready), 64'd1);
    drive(1'b1, 1'b0, 0, 64'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, 1, 64'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 0, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_rst_rdy", 64'(req_ready), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("mr_quiet", 64'(rsp_valid), 64'd0);
      @(negedge clk);
    end
    chk("mr_ready2", 64'(req_ready), 64'd1);
    chk("mr_op", 64'(mem_op), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
